// File: rtl/power_switch_sequencer.sv
// Power switch sequencer: one independent Moore FSM per power domain that
// orders isolation, retention save/restore and switch enable.
// Ports:
//   clk_i, rst_i         - clock and synchronous active-high reset
//   domain_en_i          - requested power state per domain (1 = on)
//   retention_i          - save state before power-off, per domain
//   pwr_ack_i            - power-good acknowledge per domain switch
//   pwr_sw_en_o          - power switch enable per domain
//   iso_en_o             - isolation clamp enable per domain
//   save_o, restore_o    - one-cycle retention pulses per domain
//   domain_ready_o       - domain on, restored and de-isolated
//   timeout_err_o        - sticky power-up timeout flag per domain
//   busy_o               - some domain is mid-sequence
module power_switch_sequencer #(
    parameter int NUM_DOMAINS = 5,
    parameter int ISO_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] domain_en_i,
    input  logic [NUM_DOMAINS-1:0] retention_i,
    input  logic [NUM_DOMAINS-1:0] pwr_ack_i,
    output logic [NUM_DOMAINS-1:0] pwr_sw_en_o,
    output logic [NUM_DOMAINS-1:0] iso_en_o,
    output logic [NUM_DOMAINS-1:0] save_o,
    output logic [NUM_DOMAINS-1:0] restore_o,
    output logic [NUM_DOMAINS-1:0] domain_ready_o,
    output logic [NUM_DOMAINS-1:0] timeout_err_o,
    output logic                   busy_o
);

    localparam int MAX_CYC =
        (ISO_CYCLES > ACK_TIMEOUT) ? ISO_CYCLES : ACK_TIMEOUT;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ISO_LAST = CW'(ISO_CYCLES);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT);

    localparam logic [2:0] S_ON      = 3'd0;
    localparam logic [2:0] S_ISOLATE = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_OFF     = 3'd3;
    localparam logic [2:0] S_PWRUP   = 3'd4;
    localparam logic [2:0] S_RESTORE = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    logic [NUM_DOMAINS-1:0] dom_busy;

    genvar d;
    generate
        for (d = 0; d < NUM_DOMAINS; d++) begin : g_dom
            logic [2:0]    state;
            logic [2:0]    state_nxt;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_nxt;
            logic          retained;
            logic          retained_nxt;
            logic          err;
            logic          err_nxt;

            // cnt holds the 1-based index of the current cycle in a
            // timed state, so the exit test is a plain equality.
            always_comb begin
                state_nxt    = state;
                cnt_nxt      = cnt;
                retained_nxt = retained;
                err_nxt      = err;
                unique case (state)
                    S_ON: begin
                        if (!domain_en_i[d]) begin
                            state_nxt = S_ISOLATE;
                            cnt_nxt   = ONE;
                        end
                    end
                    S_ISOLATE: begin
                        if (cnt == ISO_LAST) begin
                            state_nxt = retention_i[d] ? S_SAVE : S_OFF;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                    S_SAVE: begin
                        retained_nxt = 1'b1;
                        state_nxt    = S_OFF;
                    end
                    S_OFF: begin
                        if (domain_en_i[d]) begin
                            state_nxt = S_PWRUP;
                            cnt_nxt   = ONE;
                        end
                    end
                    S_PWRUP: begin
                        // ack is tested first so it wins over timeout
                        if (pwr_ack_i[d]) begin
                            state_nxt = S_RESTORE;
                            cnt_nxt   = '0;
                        end else if (cnt == ACK_LAST) begin
                            state_nxt = S_OFF;
                            cnt_nxt   = '0;
                            err_nxt   = 1'b1;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                    S_RESTORE: begin
                        retained_nxt = 1'b0;
                        state_nxt    = S_RELEASE;
                        cnt_nxt      = ONE;
                    end
                    S_RELEASE: begin
                        if (cnt == ISO_LAST) begin
                            state_nxt = S_ON;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                    default: begin
                        state_nxt = S_ON;
                        cnt_nxt   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state    <= S_ON;
                    cnt      <= '0;
                    retained <= 1'b0;
                    err      <= 1'b0;
                end else begin
                    state    <= state_nxt;
                    cnt      <= cnt_nxt;
                    retained <= retained_nxt;
                    err      <= err_nxt;
                end
            end

            assign pwr_sw_en_o[d]    = (state != S_OFF);
            assign iso_en_o[d]       = (state != S_ON);
            assign save_o[d]         = (state == S_SAVE);
            assign restore_o[d]      = (state == S_RESTORE) && retained;
            assign domain_ready_o[d] = (state == S_ON);
            assign timeout_err_o[d]  = err;
            assign dom_busy[d]       = (state != S_ON) && (state != S_OFF);
        end
    endgenerate

    assign busy_o = |dom_busy;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Self-checking bench for power_switch_sequencer (5 domains,
// ISO_CYCLES=2, ACK_TIMEOUT=4): vector table plus directed sequences.
module tb_power_switch_sequencer;

    logic       clk;
    logic       rst;
    logic [4:0] en;
    logic [4:0] ret;
    logic [4:0] ack;
    logic [4:0] sw;
    logic [4:0] iso;
    logic [4:0] sv;
    logic [4:0] rs;
    logic [4:0] rdy;
    logic [4:0] err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [4:0] en;
        logic [4:0] ret;
        logic [4:0] ack;
        logic [4:0] sw;
        logic [4:0] iso;
        logic [4:0] sv;
        logic [4:0] rs;
        logic [4:0] rdy;
        logic [4:0] err;
        logic       busy;
    } vec_t;

    vec_t tbl[24];
    vec_t expq[$];

    power_switch_sequencer #(
        .NUM_DOMAINS(5),
        .ISO_CYCLES (2),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .domain_en_i   (en),
        .retention_i   (ret),
        .pwr_ack_i     (ack),
        .pwr_sw_en_o   (sw),
        .iso_en_o      (iso),
        .save_o        (sv),
        .restore_o     (rs),
        .domain_ready_o(rdy),
        .timeout_err_o (err),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int step,
                       input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b",
                     nm, step, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after
    // the next rising edge, then pop and compare 1 time unit later.
    task automatic apply(input vec_t v, input int step);
        vec_t e;
        rst = v.rst;
        en  = v.en;
        ret = v.ret;
        ack = v.ack;
        expq.push_back(v);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        chk("sw",      step, sw,  e.sw);
        chk("iso",     step, iso, e.iso);
        chk("save",    step, sv,  e.sv);
        chk("restore", step, rs,  e.rs);
        chk("ready",   step, rdy, e.rdy);
        chk("err",     step, err, e.err);
        chk("busy",    step, {4'b0, busy}, {4'b0, e.busy});
    endtask

    task automatic stp(input int step, input logic r,
                       input logic [4:0] e_, input logic [4:0] rt,
                       input logic [4:0] ak, input logic [4:0] xsw,
                       input logic [4:0] xiso, input logic [4:0] xsv,
                       input logic [4:0] xrs, input logic [4:0] xrdy,
                       input logic [4:0] xerr, input logic xb);
        vec_t v;
        v = '{r, e_, rt, ak, xsw, xiso, xsv, xrs, xrdy, xerr, xb};
        apply(v, step);
    endtask

    initial begin
        rst = 1'b1;
        en  = 5'h1F;
        ret = 5'h00;
        ack = 5'h00;

        //          rst  en     ret    ack    sw     iso    save   rest   rdy    err    busy
        // reset and idle
        tbl[0]  = '{1'b1, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 1'b0};
        tbl[1]  = '{1'b0, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 1'b0};
        // d0 down, no retention: iso at t+1, sw off at t+3
        tbl[2]  = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1F, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1'b1};
        tbl[3]  = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1F, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1'b1};
        tbl[4]  = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1'b0};
        tbl[5]  = '{1'b0, 5'h1E, 5'h00, 5'h1F, 5'h1E, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1'b0};
        // d1 down with retention: save at t+3, sw off at t+4
        tbl[6]  = '{1'b0, 5'h1C, 5'h02, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[7]  = '{1'b0, 5'h1C, 5'h02, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[8]  = '{1'b0, 5'h1C, 5'h02, 5'h00, 5'h1E, 5'h03, 5'h02, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[9]  = '{1'b0, 5'h1C, 5'h00, 5'h00, 5'h1C, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b0};
        tbl[10] = '{1'b0, 5'h1C, 5'h00, 5'h00, 5'h1C, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b0};
        // d1 up, ack in 3rd POWER_UP cycle, restore pulse, 2 RELEASE
        tbl[11] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[12] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[13] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[14] = '{1'b0, 5'h1E, 5'h00, 5'h02, 5'h1E, 5'h03, 5'h00, 5'h02, 5'h1C, 5'h00, 1'b1};
        tbl[15] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[16] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h03, 5'h00, 5'h00, 5'h1C, 5'h00, 1'b1};
        tbl[17] = '{1'b0, 5'h1E, 5'h00, 5'h00, 5'h1E, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1'b0};
        // d0 up (no retained state) while d3 goes down
        tbl[18] = '{1'b0, 5'h17, 5'h00, 5'h00, 5'h1F, 5'h09, 5'h00, 5'h00, 5'h16, 5'h00, 1'b1};
        tbl[19] = '{1'b0, 5'h17, 5'h00, 5'h01, 5'h1F, 5'h09, 5'h00, 5'h00, 5'h16, 5'h00, 1'b1};
        tbl[20] = '{1'b0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h09, 5'h00, 5'h00, 5'h16, 5'h00, 1'b1};
        tbl[21] = '{1'b0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h09, 5'h00, 5'h00, 5'h16, 5'h00, 1'b1};
        tbl[22] = '{1'b0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h08, 5'h00, 5'h00, 5'h17, 5'h00, 1'b0};
        tbl[23] = '{1'b0, 5'h17, 5'h00, 5'h08, 5'h17, 5'h08, 5'h00, 5'h00, 5'h17, 5'h00, 1'b0};

        for (int i = 0; i < 24; i++) apply(tbl[i], i);

        // d2 and d4 down, then up: d2 times out, d4 acks in cycle 4
        stp(100, 0, 5'h03, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(101, 0, 5'h03, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(102, 0, 5'h03, 5'h00, 5'h00, 5'h03, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 0);
        stp(103, 0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(104, 0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(105, 0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(106, 0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h00, 1);
        stp(107, 0, 5'h13, 5'h00, 5'h10, 5'h13, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h04, 1);
        stp(108, 0, 5'h13, 5'h00, 5'h00, 5'h13, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h04, 1);
        stp(109, 0, 5'h13, 5'h00, 5'h00, 5'h13, 5'h1C, 5'h00, 5'h00, 5'h03, 5'h04, 1);
        stp(110, 0, 5'h13, 5'h00, 5'h00, 5'h13, 5'h0C, 5'h00, 5'h00, 5'h13, 5'h04, 0);
        stp(111, 0, 5'h13, 5'h00, 5'h00, 5'h13, 5'h0C, 5'h00, 5'h00, 5'h13, 5'h04, 0);

        // reset while d2 is in POWER_UP
        stp(200, 0, 5'h17, 5'h00, 5'h00, 5'h17, 5'h0C, 5'h00, 5'h00, 5'h13, 5'h04, 1);
        stp(201, 1, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 0);
        stp(202, 0, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 0);

        // reset while d0 is in SAVE
        stp(300, 0, 5'h1E, 5'h01, 5'h00, 5'h1F, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1);
        stp(301, 0, 5'h1E, 5'h01, 5'h00, 5'h1F, 5'h01, 5'h00, 5'h00, 5'h1E, 5'h00, 1);
        stp(302, 0, 5'h1E, 5'h01, 5'h00, 5'h1F, 5'h01, 5'h01, 5'h00, 5'h1E, 5'h00, 1);
        stp(303, 1, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 0);
        stp(304, 0, 5'h1F, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
